// File: rtl/sik_pkg.sv
// sik_pkg: shared opcodes, default word width and FSM state type for the Sik thread stack
package sik_pkg;
  localparam int WORD = 16;
  localparam logic [2:0] SIK_NOP   = 3'd0;
  localparam logic [2:0] SIK_PUSH  = 3'd1;
  localparam logic [2:0] SIK_POP   = 3'd2;
  localparam logic [2:0] SIK_DUP   = 3'd3;
  localparam logic [2:0] SIK_GET   = 3'd4;
  localparam logic [2:0] SIK_PUT   = 3'd5;
  localparam logic [2:0] SIK_REPL2 = 3'd6;
  localparam logic [2:0] SIK_CLR   = 3'd7;
  typedef enum logic [1:0] {CLEAR, RUN, HALTED} state_t;
endpackage

// File: rtl/sik_stack_ram.sv
// sik_stack_ram: shared flop array for all thread stacks, one sync write port, three async read ports
// clk: write clock; wr_en/wr_addr/wr_data: write port
// top_addr/next_addr/idx_addr -> top_word/next_word/idx_word: combinational reads
module sik_stack_ram #(
  parameter int WIDTH = 16,
  parameter int ENTRIES = 512,
  localparam int AW = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    top_addr,
  input  logic [AW-1:0]    next_addr,
  input  logic [AW-1:0]    idx_addr,
  output logic [WIDTH-1:0] top_word,
  output logic [WIDTH-1:0] next_word,
  output logic [WIDTH-1:0] idx_word
);
  logic [WIDTH-1:0] mem [ENTRIES];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  assign top_word  = mem[top_addr];
  assign next_word = mem[next_addr];
  assign idx_word  = mem[idx_addr];
endmodule

// File: rtl/sik_thread_stack.sv
// sik_thread_stack: THREADS independent operand stacks with fault detection, zero-fill and halt-on-error
// clk/reset: clock and async active-low reset
// op_*: one stack op per cycle when op_valid && op_ready
// rsp_*: registered result of the op accepted on the previous edge
// err: sticky per-thread fault flags; halt: unit stopped after a fault
module sik_thread_stack
  import sik_pkg::*;
#(
  parameter int WIDTH = WORD,
  parameter int THREADS = 2,
  parameter int DEPTH = 256,
  parameter bit HALT_ON_ERR = 1'b1,
  localparam int TW = THREADS > 1 ? $clog2(THREADS) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [TW-1:0]      op_thread,
  input  logic [2:0]         op_code,
  input  logic [7:0]         op_imm,
  input  logic [WIDTH-1:0]   op_data,
  output logic               rsp_valid,
  output logic [TW-1:0]      rsp_thread,
  output logic [WIDTH-1:0]   rsp_top,
  output logic [WIDTH-1:0]   rsp_next,
  output logic [CW-1:0]      rsp_count,
  output logic               rsp_err,
  output logic [THREADS-1:0] err,
  output logic               halt
);
  localparam int N = THREADS * DEPTH;
  localparam int AW = $clog2(N);
  localparam int LW = $clog2(DEPTH);
  state_t state, state_nx;
  logic [AW-1:0] clr_idx, wa;
  logic [CW-1:0] cnt [THREADS];
  logic [CW-1:0] c, c_nx;
  logic [LW-1:0] cl;
  logic [WIDTH-1:0] e1, e2, ex, wd, top_v, next_v;
  logic tv, acc, ok, we;

  // offsets are taken modulo DEPTH so every address stays inside the thread's own slice
  function automatic logic [AW-1:0] pa(input logic [TW-1:0] t, input logic [LW-1:0] o);
    return AW'(int'(t) * DEPTH + int'(o));
  endfunction

  assign tv = int'(op_thread) < THREADS;
  assign c = tv ? cnt[op_thread] : '0;
  assign cl = c[LW-1:0];
  assign op_ready = state == RUN;
  assign halt = state == HALTED;
  assign acc = op_valid && op_ready;

  // writes land on the accepting edge, so the next op reads the updated stack without a stall;
  // the indexed port serves GET, otherwise it fetches the third entry needed by pops
  sik_stack_ram #(.WIDTH(WIDTH), .ENTRIES(N)) u_ram (
    .clk,
    .wr_en(state == CLEAR || (acc && ok && we)),
    .wr_addr(state == CLEAR ? clr_idx : wa),
    .wr_data(state == CLEAR ? '0 : wd),
    .top_addr(pa(op_thread, cl - LW'(1))),
    .next_addr(pa(op_thread, cl - LW'(2))),
    .idx_addr(pa(op_thread, op_code == SIK_GET ? cl - LW'(1) - LW'(op_imm) : cl - LW'(3))),
    .top_word(e1),
    .next_word(e2),
    .idx_word(ex)
  );

  always_comb begin
    ok = 1'b1;
    c_nx = c;
    we = 1'b0;
    wa = pa(op_thread, cl);
    wd = op_data;
    top_v = e1;
    next_v = e2;
    case (op_code)
      SIK_PUSH: begin
        ok = c < CW'(DEPTH); c_nx = c + CW'(1); we = 1'b1; top_v = op_data; next_v = e1;
      end
      SIK_POP: begin
        ok = c != '0; c_nx = c - CW'(1); top_v = e2; next_v = ex;
      end
      SIK_DUP: begin
        ok = c != '0 && c < CW'(DEPTH); c_nx = c + CW'(1); we = 1'b1; wd = e1; next_v = e1;
      end
      SIK_GET: begin
        ok = int'(op_imm) < int'(c) && c < CW'(DEPTH); c_nx = c + CW'(1); we = 1'b1;
        wd = ex; top_v = ex; next_v = e1;
      end
      SIK_PUT: begin
        ok = int'(op_imm) < int'(c); c_nx = c - CW'(1); we = 1'b1;
        wa = pa(op_thread, cl - LW'(1) - LW'(op_imm)); wd = e1;
        // the overwritten slot may become the new top or next
        top_v = op_imm == 8'd1 ? e1 : e2;
        next_v = op_imm == 8'd2 ? e1 : ex;
      end
      SIK_REPL2: begin
        ok = c >= CW'(2); c_nx = c - CW'(1); we = 1'b1;
        wa = pa(op_thread, cl - LW'(2)); top_v = op_data; next_v = ex;
      end
      SIK_CLR: c_nx = '0;
      default: ;
    endcase
    ok = ok && tv;
    if (!ok) begin
      c_nx = c;
      top_v = e1;
      next_v = e2;
    end
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= CLEAR;
      clr_idx <= '0;
    end else begin
      state <= state_nx;
      clr_idx <= clr_idx + AW'(state == CLEAR);
    end

  always_comb begin
    state_nx = state;
    if (state == CLEAR && clr_idx == AW'(N - 1)) state_nx = RUN;
    if (acc && !ok && HALT_ON_ERR) state_nx = HALTED;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < THREADS; i++) cnt[i] <= '0;
      rsp_valid <= 1'b0;
      rsp_thread <= '0;
      rsp_top <= '0;
      rsp_next <= '0;
      rsp_count <= '0;
      rsp_err <= 1'b0;
      err <= '0;
    end else begin
      rsp_valid <= acc;
      if (acc) begin
        if (tv) cnt[op_thread] <= c_nx;
        if (tv && !ok) err[op_thread] <= 1'b1;
        rsp_thread <= op_thread;
        rsp_top <= c_nx != '0 ? top_v : '0;
        rsp_next <= c_nx >= CW'(2) ? next_v : '0;
        rsp_count <= c_nx;
        rsp_err <= !ok;
      end
    end
endmodule

// File: tb/tb_sik_thread_stack.sv
// tb_sik_thread_stack: directed table, corner sequences and queue-model random checks of sik_thread_stack
module tb_sik_thread_stack;
  import sik_pkg::*;
  logic clk = 1'b0, reset = 1'b0, op_valid = 1'b0;
  logic [0:0] op_thread = '0;
  logic [2:0] op_code = '0;
  logic [7:0] op_imm = '0;
  logic [15:0] op_data = '0;
  logic op_ready, rsp_valid, rsp_err, halt;
  logic [0:0] rsp_thread;
  logic [15:0] rsp_top, rsp_next;
  logic [8:0] rsp_count;
  logic [1:0] err;
  logic op_ready_h, rsp_valid_h, rsp_err_h, halt_h;
  logic [0:0] rsp_thread_h;
  logic [15:0] rsp_top_h, rsp_next_h;
  logic [8:0] rsp_count_h;
  logic [1:0] err_h;
  int vectors = 0, miscompares = 0;
  logic [1:0] err_m;
  logic [15:0] mq [2][$];

  typedef struct {int t, code, imm, d, top, nxt, cnt, e;} vec_t;
  vec_t tbl [31];

  always #5 clk = ~clk;

  sik_thread_stack #(.WIDTH(16), .THREADS(2), .DEPTH(256), .HALT_ON_ERR(1'b0)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .op_thread(op_thread),
    .op_code(op_code), .op_imm(op_imm), .op_data(op_data), .rsp_valid(rsp_valid),
    .rsp_thread(rsp_thread), .rsp_top(rsp_top), .rsp_next(rsp_next), .rsp_count(rsp_count),
    .rsp_err(rsp_err), .err(err), .halt(halt));

  sik_thread_stack #(.WIDTH(16), .THREADS(2), .DEPTH(256), .HALT_ON_ERR(1'b1)) dut_h (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready_h), .op_thread(op_thread),
    .op_code(op_code), .op_imm(op_imm), .op_data(op_data), .rsp_valid(rsp_valid_h),
    .rsp_thread(rsp_thread_h), .rsp_top(rsp_top_h), .rsp_next(rsp_next_h), .rsp_count(rsp_count_h),
    .rsp_err(rsp_err_h), .err(err_h), .halt(halt_h));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic op(input int t, input int code, input int imm, input int d);
    op_valid = 1'b1;
    op_thread = 1'(t);
    op_code = 3'(code);
    op_imm = 8'(imm);
    op_data = 16'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string name, input int t, input int top, input int nxt, input int cnt, input int e);
    chk({name, ".valid"}, 64'(rsp_valid), 64'd1);
    chk({name, ".thread"}, 64'(rsp_thread), 64'(t));
    chk({name, ".top"}, 64'(rsp_top), 64'(top));
    chk({name, ".next"}, 64'(rsp_next), 64'(nxt));
    chk({name, ".count"}, 64'(rsp_count), 64'(cnt));
    chk({name, ".err"}, 64'(rsp_err), 64'(e));
  endtask

  task automatic wait_ready(output int k);
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!op_ready && k < 2000);
  endtask

  task automatic model(input int t, input int code, input int n, input logic [15:0] d,
                       output int et, output int en, output int ec, output int ee);
    int c;
    bit legal;
    c = mq[t].size();
    legal = code == 1 ? c < 256 : code == 2 ? c >= 1 : code == 3 ? (c >= 1 && c < 256) :
            code == 4 ? (n < c && c < 256) : code == 5 ? n < c : code == 6 ? c >= 2 : 1'b1;
    if (legal)
      case (code)
        1: mq[t].push_back(d);
        2: void'(mq[t].pop_back());
        3: mq[t].push_back(mq[t][c-1]);
        4: mq[t].push_back(mq[t][c-1-n]);
        5: begin mq[t][c-1-n] = mq[t][c-1]; void'(mq[t].pop_back()); end
        6: begin void'(mq[t].pop_back()); void'(mq[t].pop_back()); mq[t].push_back(d); end
        7: mq[t].delete();
        default: ;
      endcase
    ec = mq[t].size();
    et = ec >= 1 ? int'(mq[t][ec-1]) : 0;
    en = ec >= 2 ? int'(mq[t][ec-2]) : 0;
    ee = legal ? 0 : 1;
  endtask

  task automatic rop(input int t, input int code, input int n, input logic [15:0] d);
    int et, en, ec, ee;
    model(t, code, n, d, et, en, ec, ee);
    if (ee != 0) err_m[t] = 1'b1;
    op(t, code, n, int'(d));
    chk_rsp("rand", t, et, en, ec, ee);
    chk("rand.err_flags", 64'(err), 64'(err_m));
  endtask

  initial begin
    int k;
    int cmap [16];
    cmap = '{1, 1, 1, 1, 1, 1, 2, 2, 3, 4, 4, 5, 6, 0, 2, 7};
    tbl = '{
      '{1, 1, 0, 'h1111, 'h1111, 0, 1, 0}, '{1, 1, 0, 'h2222, 'h2222, 'h1111, 2, 0},
      '{1, 2, 0, 0, 'h1111, 0, 1, 0},      '{1, 2, 0, 0, 0, 0, 0, 0},
      '{0, 1, 0, 5, 5, 0, 1, 0},           '{1, 1, 0, 9, 9, 0, 1, 0},
      '{0, 1, 0, 6, 6, 5, 2, 0},           '{1, 0, 0, 0, 9, 0, 1, 0},
      '{1, 7, 0, 0, 0, 0, 0, 0},           '{0, 7, 0, 0, 0, 0, 0, 0},
      '{0, 1, 0, 10, 10, 0, 1, 0},         '{0, 1, 0, 20, 20, 10, 2, 0},
      '{0, 1, 0, 30, 30, 20, 3, 0},        '{0, 1, 0, 40, 40, 30, 4, 0},
      '{0, 4, 2, 0, 20, 40, 5, 0},         '{0, 5, 3, 0, 40, 30, 4, 0},
      '{0, 4, 4, 0, 40, 30, 4, 1},         '{0, 5, 1, 0, 40, 20, 3, 0},
      '{0, 5, 2, 0, 20, 40, 2, 0},         '{0, 5, 0, 0, 40, 0, 1, 0},
      '{0, 6, 0, 99, 40, 0, 1, 1},         '{0, 3, 0, 0, 40, 40, 2, 0},
      '{0, 7, 0, 0, 0, 0, 0, 0},           '{0, 1, 0, 3, 3, 0, 1, 0},
      '{0, 1, 0, 4, 4, 3, 2, 0},           '{0, 6, 0, 7, 7, 0, 1, 0},
      '{0, 7, 0, 0, 0, 0, 0, 0},           '{0, 2, 0, 0, 0, 0, 0, 1},
      '{0, 3, 0, 0, 0, 0, 0, 1},           '{0, 5, 0, 0, 0, 0, 0, 1},
      '{0, 4, 0, 0, 0, 0, 0, 1}
    };
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {op_ready, rsp_valid, rsp_thread, rsp_top, rsp_next, rsp_count, rsp_err, err, halt,
                          op_ready_h, halt_h}, 64'd0);
    reset = 1'b1;
    wait_ready(k);
    chk("ready_latency", 64'(k), 64'd512);
    chk("ready_latency_h", 64'(op_ready_h), 64'd1);
    op(0, 2, 0, 0);
    chk_rsp("first_pop", 0, 0, 0, 0, 1);
    chk("first_pop.err_flags", 64'(err), 64'd1);
    chk("first_pop.halt_off", 64'(halt), 64'd0);
    chk("halt_mode.halt", 64'(halt_h), 64'd1);
    chk("halt_mode.ready", 64'(op_ready_h), 64'd0);
    chk("halt_mode.rsp_err", 64'(rsp_err_h), 64'd1);
    for (int i = 0; i < 31; i++) begin
      op(tbl[i].t, tbl[i].code, tbl[i].imm, tbl[i].d);
      chk_rsp($sformatf("tbl%0d", i), tbl[i].t, tbl[i].top, tbl[i].nxt, tbl[i].cnt, tbl[i].e);
    end
    chk("err_after_table", 64'(err), 64'd1);
    chk("halted_stays", 64'(halt_h), 64'd1);
    for (int i = 0; i < 256; i++) op(0, 1, 0, i);
    chk_rsp("fill", 0, 255, 254, 256, 0);
    op(0, 1, 0, 'hdead);
    chk_rsp("overflow", 0, 255, 254, 256, 1);
    op(1, 1, 0, 'habc);
    chk_rsp("other_thread", 1, 'habc, 0, 1, 0);
    chk("err_after_fill", 64'(err), 64'd1);
    err_m = 2'b01;
    mq[0].delete();
    mq[1].delete();
    rop(0, 7, 0, 0);
    rop(1, 7, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        op_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("idle.valid", 64'(rsp_valid), 64'd0);
      end else
        rop(int'($urandom_range(0, 1)), cmap[$urandom_range(0, 15)], int'($urandom_range(0, 7)), 16'($urandom));
    end
    op(0, 1, 0, 'h55);
    chk("pre_reset.count_nonzero", 64'(rsp_count != 0), 64'd1);
    op_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("async_reset", {op_ready, rsp_valid, rsp_thread, rsp_top, rsp_next, rsp_count, rsp_err, err, halt}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    wait_ready(k);
    chk("rerun_latency", 64'(k), 64'd512);
    chk("halt_cleared", 64'({halt_h, op_ready_h}), 64'b01);
    op(0, 0, 0, 0);
    chk_rsp("post_reset_nop", 0, 0, 0, 0, 0);
    op(1, 1, 0, 'h77);
    chk_rsp("post_reset_push", 1, 'h77, 0, 1, 0);
    op_valid = 1'b0;
    repeat (100) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_clear_reset", {op_ready, rsp_valid, rsp_top, rsp_count}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    wait_ready(k);
    chk("reclear_latency", 64'(k), 64'd512);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sik_thread_stack.md
# sik_thread_stack

Parametrised multi-thread operand-stack unit for the Sik stack processor. It generalises the two fixed 256-entry thread stacks to THREADS independent stacks of DEPTH words each, held in one shared array. It adds overflow/underflow detection, indexed get/put, a post-reset zero-fill sequence and an optional halt-on-error mode. It sits between the decode stage, which issues one stack op per cycle, and the ALU/write-back stage, which consumes the new top two entries.

## Interface
Parameters:
- WIDTH, 16, stack word width
- THREADS, 2, number of independent stacks (≥1)
- DEPTH, 256, entries per stack (power of 2, ≥4)
- HALT_ON_ERR, 1, any stack fault halts the unit
- Derived: TW = max(1, clog2(THREADS)), CW = clog2(DEPTH+1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset; one clock domain, clk
- op_valid  in  1  op offered this cycle
- op_ready  out  1  unit accepts the op this cycle
- op_thread  in  TW  target stack
- op_code  in  3  operation, see Operation
- op_imm  in  8  offset for GET/PUT
- op_data  in  WIDTH  value for PUSH/REPL2
- rsp_valid  out  1  response for the op accepted last cycle
- rsp_thread  out  TW  thread of the response
- rsp_top  out  WIDTH  top entry after the op; 0 if absent
- rsp_next  out  WIDTH  entry below the top after the op; 0 if absent
- rsp_count  out  CW  entries in that thread's stack after the op
- rsp_err  out  1  the op faulted and had no effect
- err  out  THREADS  sticky per-thread fault flags
- halt  out  1  unit halted

## Operation
- Opcodes: 000 NOP, 001 PUSH op_data, 010 POP, 011 DUP, 100 GET, 101 PUT, 110 REPL2, 111 CLR.
- Each thread has a count c (0..DEPTH). The top lives at physical index thread*DEPTH + c-1.
- Legality conditions, where n = op_imm:
  - PUSH: c<DEPTH
  - POP: c≥1
  - DUP: 1≤c<DEPTH
  - GET: n<c and c<DEPTH; pushes entry[top-n]
  - PUT: n<c; writes the top into entry[top-n], then pops. n=0 behaves as POP.
  - REPL2: c≥2; pops two entries and pushes op_data (ALU write-back)
  - CLR: always legal; sets c=0 and does not scrub data
  - NOP: always legal
- An illegal op changes no state. It asserts rsp_err and sets err[op_thread].
- If HALT_ON_ERR=1, an illegal op also moves the FSM to HALTED.
- FSM states:
  - CLEAR: zero-fills one physical entry per cycle, from index 0 to THREADS*DEPTH-1. op_ready=0. Exits to RUN after the last index.
  - RUN: op_ready=1.
  - HALTED: op_ready=0 and halt=1. Exit only via reset.
- Threads are fully independent. An op on one thread never alters another thread's count or entries.

## Timing
- Reset, asserted asynchronously: FSM=CLEAR, clear index 0, all counts 0, op_ready=0, rsp_valid=0, rsp_* =0, err=0, halt=0.
- Reset asserted mid-CLEAR or mid-RUN aborts all activity. After release, CLEAR restarts from index 0.
- First op_ready=1 occurs exactly THREADS*DEPTH cycles after the first clk edge following reset release.
- An op is accepted on an edge where op_valid and op_ready are both high. op_valid while op_ready=0 is ignored and not queued.
- Throughput is one op per cycle. Back-to-back ops to the same thread see the previous op's result with no stall; internal forwarding is required.
- Response latency is 1 cycle. rsp_* are registered, valid only while rsp_valid=1, and hold their values otherwise.
- An accepted NOP still produces a response with the current top, next and count.
- Halting op: its response (rsp_err=1) appears in the cycle after acceptance. halt and op_ready=0 take effect on the same edge the op is accepted.

## Structure
- Shared package sik_pkg holds:
  - opcode constants SIK_NOP..SIK_CLR
  - default WORD width 16
  - the FSM state typedef (CLEAR, RUN, HALTED)
- Sub-module sik_stack_ram: THREADS*DEPTH × WIDTH flop array with one synchronous write port and three asynchronous read ports (top, next, indexed).
- The top level holds the counts, the FSM, legality checks, forwarding and the response registers.

## Test plan
- Reset release with THREADS=2, DEPTH=256: op_ready rises after exactly 512 cycles. An immediate POP on thread 0 then gives rsp_err=1 and err=01. With HALT_ON_ERR=1, halt=1.
- PUSH 0x1111, then PUSH 0x2222, on thread 1 -> second response top=0x2222, next=0x1111, count=2. Same-cycle-later POP -> top=0x1111, next=0, count=1.
- Interleaved pushes: thread 0 pushes 5, thread 1 pushes 9, thread 0 pushes 6 -> thread 0 top=6, next=5, count=2. A NOP on thread 1 gives top=9, count=1.
- Fill thread 0 with 256 PUSHes, then one more PUSH -> rsp_err=1, count stays 256, err[0]=1. Thread 1 is still usable when HALT_ON_ERR=0.
- Stack 10,20,30,40 (top=40):
  - GET imm=2 -> top=20, count=5.
  - PUT imm=3 then writes 20 over the entry holding 20 and pops -> top=40, count=4.
  - GET imm=4 with count=4 -> rsp_err=1.
- Stack 3,4, then REPL2 with data 7 -> top=7, count=1. CLR -> count=0, top=0. Reset asserted mid-run -> all outputs 0 and CLEAR restarts.
